// File: rtl/keccak_share_io_pkg.sv
// Shared definitions for the masked Keccak share I/O wrapper: FSM states,
// fresh-mask width formula and default watchdog limit.
package keccak_share_io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int MAX_CYC_DEF = 32;

   // Fresh mask bits for a (sin)-share core: one b-bit mask per share pair.
   function automatic int nr_bits(input int sin, input int width);
      return sin * (sin - 1) / 2 * width;
   endfunction

endpackage

// File: rtl/keccak_share_recombine.sv
// Recombines n_shares b-bit Boolean shares into the plain value by XOR.
module keccak_share_recombine #(
   parameter int b        = 25,
   parameter int n_shares = 2
) (
   input  logic [n_shares*b-1:0] shares,
   output logic [b-1:0]          plain
);

   always_comb begin
      plain = '0;
      for (int i = 0; i < n_shares; i++) begin
         plain = plain ^ shares[i*b +: b];
      end
   end

endmodule

// File: rtl/keccak_share_io.sv
// Masking front end / unmasking back end around a d-th order masked Keccak core.
// Optional build macro KECCAK_SHARE_IO_ZEROIZE_EN clears shares and result after use.
//
//   state   | meaning
//   IDLE    | waiting for plain input; core held in reset
//   LOAD    | one cycle, masked shares presented to core while in reset
//   RUN     | core running, watchdog counting
//   DONE    | recombined result offered until taken
module keccak_share_io
   import keccak_share_io_pkg::*;
#(
   parameter int b       = 25,
   parameter int W       = 1,
   parameter int d       = 1,
   parameter int MAX_CYC = MAX_CYC_DEF
) (
   input  logic                                  Clock,
   input  logic                                  Reset,
   input  logic                                  InValid,
   output logic                                  InReady,
   input  logic [b-1:0]                          InPlain,
   input  logic [d*b+nr_bits(d+1, b)-1:0]        RandIn,
   output logic                                  CoreReset,
   output logic [(d+1)*b-1:0]                    CoreInData,
   output logic [nr_bits(d+1, b)-1:0]            CoreFreshRand,
   input  logic                                  CoreReady,
   input  logic [(d+1)*b-1:0]                    CoreOutData,
   output logic                                  OutValid,
   input  logic                                  OutReady,
   output logic [b-1:0]                          OutPlain,
   output logic                                  Busy,
   output logic                                  Timeout
);

   localparam int SIN = d + 1;
   localparam int NR  = nr_bits(SIN, b);
   localparam int WDW = $clog2(MAX_CYC + 1);

   if (W * 25 != b) begin : g_bad_width
      $error("keccak_share_io: lane width W must equal b/25");
   end

   state_t           state, state_nxt;
   logic [SIN*b-1:0] shares;
   logic [SIN*b-1:0] in_shares;
   logic [b-1:0]     recombined;
   logic [WDW-1:0]   wd;
   logic             in_fire, cap, wd_expire;
`ifdef KECCAK_SHARE_IO_ZEROIZE_EN
   logic             out_fire;
`endif

   assign in_fire   = (state == ST_IDLE) && InValid;
   assign cap       = (state == ST_RUN) && CoreReady;
   assign wd_expire = (state == ST_RUN) && !CoreReady && (wd == WDW'(MAX_CYC - 1));
`ifdef KECCAK_SHARE_IO_ZEROIZE_EN
   assign out_fire  = (state == ST_DONE) && OutReady;
`endif

   // Shares 0..d-1 are raw random slices; the last share carries the plain value.
   always_comb begin
      in_shares = '0;
      in_shares[d*b +: b] = InPlain;
      for (int i = 0; i < d; i++) begin
         in_shares[i*b +: b] = RandIn[i*b +: b];
         in_shares[d*b +: b] = in_shares[d*b +: b] ^ RandIn[i*b +: b];
      end
   end

   keccak_share_recombine #(
      .b        (b),
      .n_shares (SIN)
   ) u_recombine (
      .shares (CoreOutData),
      .plain  (recombined)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      InReady   = 1'b0;
      OutValid  = 1'b0;
      CoreReset = 1'b1;
      Busy      = 1'b1;
      unique case (state)
         ST_IDLE: begin
            InReady = 1'b1;
            Busy    = 1'b0;
            if (InValid) state_nxt = ST_LOAD;
         end
         ST_LOAD: state_nxt = ST_RUN;
         ST_RUN: begin
            CoreReset = 1'b0;
            if (CoreReady)      state_nxt = ST_DONE;
            else if (wd_expire) state_nxt = ST_IDLE;
         end
         ST_DONE: begin
            OutValid = 1'b1;
            if (OutReady) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The plain result is only formed at capture, straight into the output register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         shares   <= '0;
         OutPlain <= '0;
         wd       <= '0;
         Timeout  <= 1'b0;
      end else begin
         if (in_fire) begin
            shares  <= in_shares;
            Timeout <= 1'b0;
         end else if (cap) begin
            shares   <= CoreOutData;
            OutPlain <= recombined;
         end
`ifdef KECCAK_SHARE_IO_ZEROIZE_EN
         else if (out_fire || wd_expire) begin
            shares   <= '0;
            OutPlain <= '0;
         end
`endif
         if (wd_expire) Timeout <= 1'b1;
         if (state == ST_LOAD)     wd <= '0;
         else if (state == ST_RUN) wd <= wd + WDW'(1);
      end
   end

   assign CoreInData    = shares;
   assign CoreFreshRand = RandIn[d*b +: NR];

endmodule

// File: tb/tb_keccak_share_io.sv
// Bench for keccak_share_io: acts as the masked core using a Keccak-f[25] model
// and checks masking, unmasking, handshakes, watchdog and reset behaviour.
module tb_keccak_share_io;

   localparam int B   = 25;
   localparam int D   = 1;
   localparam int SIN = D + 1;
   localparam int NR  = SIN * (SIN - 1) / 2 * B;
   localparam int RW  = D * B + NR;

   logic             Clock = 1'b0;
   logic             Reset = 1'b0;
   logic             InValid = 1'b0;
   logic             InReady;
   logic [B-1:0]     InPlain = '0;
   logic [RW-1:0]    RandIn = '0;
   logic             CoreReset;
   logic [SIN*B-1:0] CoreInData;
   logic [NR-1:0]    CoreFreshRand;
   logic             CoreReady = 1'b0;
   logic [SIN*B-1:0] CoreOutData = '0;
   logic             OutValid;
   logic             OutReady = 1'b0;
   logic [B-1:0]     OutPlain;
   logic             Busy;
   logic             Timeout;

   int               total = 0;
   int               bad = 0;
   logic             exp_done = 1'b0;
   logic [B-1:0]     exp_plain = '0;

   keccak_share_io #(
      .b       (B),
      .W       (1),
      .d       (D),
      .MAX_CYC (32)
   ) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .InValid       (InValid),
      .InReady       (InReady),
      .InPlain       (InPlain),
      .RandIn        (RandIn),
      .CoreReset     (CoreReset),
      .CoreInData    (CoreInData),
      .CoreFreshRand (CoreFreshRand),
      .CoreReady     (CoreReady),
      .CoreOutData   (CoreOutData),
      .OutValid      (OutValid),
      .OutReady      (OutReady),
      .OutPlain      (OutPlain),
      .Busy          (Busy),
      .Timeout       (Timeout)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   // Keccak-f[25]: 1-bit lanes, bit x+5y; rho is the identity for w=1.
   function automatic logic [24:0] kf_rounds(input logic [24:0] s_in, input int nr);
      logic        a [5][5];
      logic        bb[5][5];
      logic        c [5];
      logic        dd[5];
      logic [11:0] rc;
      logic [24:0] s_out;
      rc = 12'b0100_1111_0001;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++) a[x][y] = s_in[x + 5*y];
      for (int r = 0; r < nr; r++) begin
         for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
         for (int x = 0; x < 5; x++) dd[x] = c[(x+4)%5] ^ c[(x+1)%5];
         for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) a[x][y] = a[x][y] ^ dd[x];
         for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) bb[y][(2*x + 3*y)%5] = a[x][y];
         for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
               a[x][y] = bb[x][y] ^ (~bb[(x+1)%5][y] & bb[(x+2)%5][y]);
         a[0][0] = a[0][0] ^ rc[r];
      end
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++) s_out[x + 5*y] = a[x][y];
      return s_out;
   endfunction

   function automatic logic [RW-1:0] rand_vec();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      if ($urandom_range(0, 15) == 0) t[D*B-1:0] = '0;
      return t[RW-1:0];
   endfunction

   initial forever begin
      @(negedge Clock);
      #1;
      RandIn = rand_vec();
   end

   always @(negedge Clock) begin
      check("fresh_rand", 64'(CoreFreshRand), 64'(RandIn[D*B +: NR]));
      check("in_ready_vs_busy", 64'(InReady), 64'(!Busy));
      check("out_valid", 64'(OutValid), 64'(exp_done));
      if (exp_done) check("out_plain", 64'(OutPlain), 64'(exp_plain));
   end

   // Presents one input and returns once the handshake edge has passed (DUT in LOAD).
   task automatic send(input logic [B-1:0] plain, output logic [D*B-1:0] rnd);
      int n;
      InPlain = plain;
      InValid = 1'b1;
      n = 0;
      while (!InReady && n < 200) begin
         tick;
         n++;
      end
      check("in_ready_wait", 64'(InReady), 64'd1);
      tick;
      rnd = RandIn[D*B-1:0];
      InValid = 1'b0;
      InPlain = B'($urandom());
   endtask

   task automatic txn(input logic [B-1:0] plain, input int lat, input int hold);
      logic [D*B-1:0]   rnd;
      logic [SIN*B-1:0] cin;
      logic [SIN*B-1:0] cout;
      logic [B-1:0]     m;
      send(plain, rnd);
      check("load_core_reset", 64'(CoreReset), 64'd1);
      check("load_timeout_clear", 64'(Timeout), 64'd0);
      check("share0", 64'(CoreInData[0 +: B]), 64'(rnd));
      check("share1", 64'(CoreInData[B +: B]), 64'(plain ^ rnd));
      check("share1_masked", 64'(CoreInData[B +: B] == plain), 64'(rnd == '0));
      cin = CoreInData;
      tick;
      check("run_core_reset", 64'(CoreReset), 64'd0);
      for (int i = 0; i < lat; i++) tick;
      m    = B'($urandom());
      cout = {kf_rounds(cin[0 +: B] ^ cin[B +: B], 12) ^ m, m};
      CoreReady   = 1'b1;
      CoreOutData = cout;
      tick;
      exp_plain = kf_rounds(plain, 12);
      exp_done  = 1'b1;
      check("done_in_ready", 64'(InReady), 64'd0);
      for (int i = 0; i < hold; i++) begin
         CoreOutData = {B'($urandom()), B'($urandom())};
         tick;
         check("hold_in_ready", 64'(InReady), 64'd0);
         check("hold_out_plain", 64'(OutPlain), 64'(exp_plain));
      end
      CoreReady = 1'b0;
      OutReady  = 1'b1;
      tick;
      OutReady = 1'b0;
      exp_done = 1'b0;
      check("idle_after_out", 64'(Busy), 64'd0);
`ifdef KECCAK_SHARE_IO_ZEROIZE_EN
      check("zeroize_shares", 64'(CoreInData), 64'd0);
      check("zeroize_plain", 64'(OutPlain), 64'd0);
`else
      check("retain_shares", 64'(CoreInData), 64'(cout));
      check("retain_plain", 64'(OutPlain), 64'(exp_plain));
`endif
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, 64'(InReady), 64'd1);
      check({tag, "_busy"}, 64'(Busy), 64'd0);
      check({tag, "_out_valid"}, 64'(OutValid), 64'd0);
      check({tag, "_timeout"}, 64'(Timeout), 64'd0);
      check({tag, "_core_reset"}, 64'(CoreReset), 64'd1);
      check({tag, "_out_plain"}, 64'(OutPlain), 64'd0);
      check({tag, "_core_in"}, 64'(CoreInData), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit actual=running required=finished");
      $fatal(1, "time limit");
   end

   initial begin
      logic [D*B-1:0] rnd;
      #2;
      check_reset_values("rst");
      @(posedge Clock);
      #1;
      Reset = 1'b1;
      tick;

      // Model pins: zero state after 1 and 2 rounds, worked by hand.
      check("model_round1", 64'(kf_rounds('0, 1)), 64'h1);
      check("model_round2", 64'(kf_rounds('0, 2)), 64'h1160F17);

      txn('0, 3, 0);

      // Core completion outside RUN is ignored.
      CoreReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("idle_core_ready", 64'(Busy), 64'd0);
      end
      CoreReady = 1'b0;

      txn(B'($urandom()), 5, 10);

      for (int i = 0; i < 1000; i++)
         txn(B'($urandom()), $urandom_range(0, 20), $urandom_range(0, 3));

      // Watchdog: core never completes.
      send(B'($urandom()), rnd);
      for (int i = 0; i < 32; i++) begin
         tick;
         check("wd_busy", 64'(Busy), 64'd1);
         check("wd_core_reset", 64'(CoreReset), 64'd0);
         check("wd_timeout_early", 64'(Timeout), 64'd0);
      end
      tick;
      check("wd_timeout", 64'(Timeout), 64'd1);
      check("wd_idle", 64'(Busy), 64'd0);
`ifdef KECCAK_SHARE_IO_ZEROIZE_EN
      check("wd_zeroize", 64'(CoreInData), 64'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         tick;
         check("wd_timeout_sticky", 64'(Timeout), 64'd1);
      end
      txn(B'($urandom()), 2, 1);

      // Reset in the middle of RUN discards everything.
      send(B'($urandom()), rnd);
      tick;
      tick;
      Reset = 1'b0;
      #1;
      check_reset_values("midrun");
      tick;
      Reset = 1'b1;
      CoreReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         CoreOutData = {B'($urandom()), B'($urandom())};
         tick;
         check("post_reset_idle", 64'(Busy), 64'd0);
      end
      CoreReady = 1'b0;

      txn(B'($urandom()), 0, 2);
      tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
